avalon_mm_word_copier: RTL and testbench

//  Avalon-MM master (initiator) that copies a block of 32-bit words from one word address range to another.

---
 rtl/avalon_copier_pkg.sv | 18 +
 rtl/avalon_mm_word_copier.sv | 157 +++++++++++++++
 tb/tb_avalon_mm_word_copier.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_copier_pkg.sv
// Shared types and constants for the Avalon-MM word copier.
// Holds the FSM state encoding and the fixed Avalon data/byteenable widths.
// The RAM slave is 32 bits wide, so all four byte lanes are enabled on every write.
package avalon_copier_pkg;

  localparam int AVM_DATA_W = 32;
  localparam int AVM_BE_W   = 4;
  localparam logic [AVM_BE_W-1:0] BE_ALL = 4'hF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/avalon_mm_word_copier.sv
// Avalon-MM master copying N 32-bit words: read one word, write it, advance (one outstanding access).
// Latency: with waitrequest=0 and READ_LATENCY=1, 3 cycles per word; done arrives 1+3N cycles after the accepted start.
// Backpressure: waitrequest holds the current strobe, address and writedata unchanged; optional COPIER_CHECKSUM_EN adds o_checksum.
module avalon_mm_word_copier
  import avalon_copier_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_W-1:0]     i_src_addr,
  input  logic [ADDR_W-1:0]     i_dst_addr,
  input  logic [ADDR_W:0]       i_length,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_W-1:0]     o_master_address,
  output logic                  o_master_read,
  output logic                  o_master_write,
  output logic [AVM_BE_W-1:0]   o_master_byteenable,
  output logic [AVM_DATA_W-1:0] o_master_writedata,
  input  logic [AVM_DATA_W-1:0] i_master_readdata,
  input  logic                  i_master_waitrequest
`ifdef COPIER_CHECKSUM_EN
  ,
  output logic [AVM_DATA_W-1:0] o_checksum
`endif
);

  // READ_LATENCY is at most 4, so a 3-bit counter covers every legal setting.
  localparam int LAT_W = 3;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_W-1:0]     r_src_ptr;
  logic [ADDR_W-1:0]     r_dst_ptr;
  logic [ADDR_W:0]       r_remaining;
  logic [AVM_DATA_W-1:0] r_data;
  logic [LAT_W-1:0]      r_lat_cnt;
  logic                  w_start_acc;
  logic                  w_wr_acc;
  logic                  w_capture;

  // State register; reset abandons any copy in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and Moore-style bus outputs; strobes depend only on state so they hold under waitrequest.
  always_comb begin
    w_state_nxt         = r_state;
    w_start_acc         = 1'b0;
    w_wr_acc            = 1'b0;
    w_capture           = 1'b0;
    o_busy              = 1'b0;
    o_done              = 1'b0;
    o_master_read       = 1'b0;
    o_master_write      = 1'b0;
    o_master_address    = '0;
    o_master_byteenable = '0;
    o_master_writedata  = '0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_start_acc = 1'b1;
          w_state_nxt = (i_length == '0) ? DONE : RD_REQ;
        end
      end
      RD_REQ: begin
        o_busy           = 1'b1;
        o_master_read    = 1'b1;
        o_master_address = r_src_ptr;
        if (!i_master_waitrequest) begin
          w_state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        o_busy = 1'b1;
        if (r_lat_cnt == LAT_LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = WR_REQ;
        end
      end
      WR_REQ: begin
        o_busy              = 1'b1;
        o_master_write      = 1'b1;
        o_master_address    = r_dst_ptr;
        o_master_byteenable = BE_ALL;
        o_master_writedata  = r_data;
        if (!i_master_waitrequest) begin
          w_wr_acc    = 1'b1;
          w_state_nxt = (r_remaining == (ADDR_W+1)'(1)) ? DONE : RD_REQ;
        end
      end
      DONE: begin
        o_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Pointers, word count and read-latency counter; pointers wrap naturally at 2^ADDR_W.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_src_ptr   <= '0;
      r_dst_ptr   <= '0;
      r_remaining <= '0;
      r_data      <= '0;
      r_lat_cnt   <= '0;
    end else begin
      if (w_start_acc) begin
        r_src_ptr   <= i_src_addr;
        r_dst_ptr   <= i_dst_addr;
        r_remaining <= i_length;
      end else if (w_wr_acc) begin
        r_src_ptr   <= r_src_ptr + 1'b1;
        r_dst_ptr   <= r_dst_ptr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
      if (r_state == RD_WAIT) begin
        r_lat_cnt <= r_lat_cnt + 1'b1;
      end else begin
        r_lat_cnt <= '0;
      end
      if (w_capture) begin
        r_data <= i_master_readdata;
      end
    end
  end

`ifdef COPIER_CHECKSUM_EN
  logic [AVM_DATA_W-1:0] r_checksum;

  // Running modulo-2^32 sum of every accepted write; holds its value between done and the next start.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_checksum <= '0;
    end else if (w_start_acc) begin
      r_checksum <= '0;
    end else if (w_wr_acc) begin
      r_checksum <= r_checksum + o_master_writedata;
    end
  end

  assign o_checksum = r_checksum;
`endif

endmodule

// File: tb/tb_avalon_mm_word_copier.sv
// Directed bench for avalon_mm_word_copier against a 1024-word RAM model with read latency 1.
// Latency: checks done/busy cycle positions relative to the accepted start.
// Backpressure: optional random waitrequest stalls with a stability monitor.
module tb_avalon_mm_word_copier;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [9:0]  i_src_addr;
  logic [9:0]  i_dst_addr;
  logic [10:0] i_length;
  logic        o_busy;
  logic        o_done;
  logic [9:0]  o_master_address;
  logic        o_master_read;
  logic        o_master_write;
  logic [3:0]  o_master_byteenable;
  logic [31:0] o_master_writedata;
  logic [31:0] i_master_readdata;
  logic        i_master_waitrequest;
`ifdef COPIER_CHECKSUM_EN
  logic [31:0] o_checksum;
`endif

  int checks = 0;
  int errors = 0;

  avalon_mm_word_copier #(.ADDR_W(10), .READ_LATENCY(1)) dut (
    .i_clk                (clk),
    .i_reset              (i_reset),
    .i_start              (i_start),
    .i_src_addr           (i_src_addr),
    .i_dst_addr           (i_dst_addr),
    .i_length             (i_length),
    .o_busy               (o_busy),
    .o_done               (o_done),
    .o_master_address     (o_master_address),
    .o_master_read        (o_master_read),
    .o_master_write       (o_master_write),
    .o_master_byteenable  (o_master_byteenable),
    .o_master_writedata   (o_master_writedata),
    .i_master_readdata    (i_master_readdata),
    .i_master_waitrequest (i_master_waitrequest)
`ifdef COPIER_CHECKSUM_EN
    ,
    .o_checksum           (o_checksum)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: registered read (latency 1), write on accepted strobe, plus a backdoor write port.
  logic [31:0] mem [0:1023];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;
  logic        stall_en = 1'b0;
  logic        wreq = 1'b0;

  assign i_master_waitrequest = wreq;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (o_master_write && !wreq) mem[o_master_address] <= o_master_writedata;
    if (o_master_read && !wreq) i_master_readdata <= mem[o_master_address];
    wreq <= stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Bus activity log: accepted read addresses and write/strobe counts.
  logic [9:0] rd_log [0:63];
  int rd_cnt = 0;
  int wr_cnt = 0;
  int strobe_cnt = 0;
  int both_cnt = 0;
  always @(posedge clk) begin
    if (!i_reset) begin
      if (o_master_read && !wreq) begin
        rd_log[rd_cnt[5:0]] <= o_master_address;
        rd_cnt <= rd_cnt + 1;
      end
      if (o_master_write && !wreq) wr_cnt <= wr_cnt + 1;
      if (o_master_read || o_master_write) strobe_cnt <= strobe_cnt + 1;
      if (o_master_read && o_master_write) both_cnt <= both_cnt + 1;
    end
  end

  // Stability monitor: a stalled strobe must reappear unchanged the next cycle.
  int   stab_err = 0;
  logic p_stall = 1'b0;
  logic p_rd, p_wr;
  logic [9:0]  p_addr;
  logic [31:0] p_wd;
  always @(negedge clk) begin
    if (p_stall && !i_reset) begin
      if (o_master_read !== p_rd || o_master_write !== p_wr ||
          o_master_address !== p_addr || o_master_writedata !== p_wd)
        stab_err = stab_err + 1;
    end
    p_stall = (o_master_read || o_master_write) && wreq;
    p_rd    = o_master_read;
    p_wr    = o_master_write;
    p_addr  = o_master_address;
    p_wd    = o_master_writedata;
  end

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Launch a copy and watch until done; k=1 is the first cycle after the accepted start.
  task automatic run_copy(input logic [9:0] s, input logic [9:0] d, input logic [10:0] n,
                          input int budget, output int done_k, output int busy_cnt,
                          output int busy_first, output int busy_last);
    @(negedge clk);
    i_src_addr = s; i_dst_addr = d; i_length = n; i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    done_k = -1; busy_cnt = 0; busy_first = -1; busy_last = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (o_busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = k;
        busy_last = k;
      end
      if (o_done) begin
        done_k = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    i_reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_busy, o_done, o_master_read, o_master_write} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {o_busy, o_done, o_master_read, o_master_write});
    end
    checks++;
    if (o_master_address !== 10'd0 || o_master_byteenable !== 4'h0 || o_master_writedata !== 32'h0) begin
      errors++; $display("FAIL reset_bus: addr=%h be=%h wd=%h expected all 0", o_master_address, o_master_byteenable, o_master_writedata);
    end
    i_reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b done=%b expected 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_basic_copy;
    int dk, bc, bf, bl, r0;
    for (int i = 0; i < 4; i++) poke(10'(i), 32'hA0A0_0000 + i);
    r0 = rd_cnt;
    run_copy(10'd0, 10'd16, 11'd4, 40, dk, bc, bf, bl);
    checks++;
    if (dk !== 13) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 13", dk); end
    checks++;
    if (bc !== 12 || bf !== 1 || bl !== 12) begin
      errors++; $display("FAIL basic_busy: cnt=%0d first=%0d last=%0d expected 12 1 12", bc, bf, bl);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16+i] !== 32'hA0A0_0000 + i) begin
        errors++; $display("FAIL basic_data%0d: got %h expected %h", i, mem[16+i], 32'hA0A0_0000 + i);
      end
    end
    checks++;
    if (rd_cnt - r0 !== 4) begin errors++; $display("FAIL basic_reads: got %0d expected 4", rd_cnt - r0); end
  endtask

  task automatic test_zero_length;
    int dk, bc, bf, bl, s0;
    s0 = strobe_cnt;
    run_copy(10'd0, 10'd50, 11'd0, 10, dk, bc, bf, bl);
    checks++;
    if (dk !== 1) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 1", dk); end
    checks++;
    if (bc !== 0) begin errors++; $display("FAIL zero_busy: got %0d expected 0", bc); end
    repeat (2) @(negedge clk);
    checks++;
    if (strobe_cnt - s0 !== 0) begin errors++; $display("FAIL zero_strobes: got %0d expected 0", strobe_cnt - s0); end
  endtask

  task automatic test_wrap;
    int dk, bc, bf, bl, r0;
    logic [9:0] exp_a [0:2];
    logic [31:0] exp_d [0:2];
    exp_a[0] = 10'd1022; exp_a[1] = 10'd1023; exp_a[2] = 10'd0;
    exp_d[0] = 32'hB000_1022; exp_d[1] = 32'hB000_1023; exp_d[2] = 32'hB000_0000;
    for (int i = 0; i < 3; i++) poke(exp_a[i], exp_d[i]);
    r0 = rd_cnt;
    run_copy(10'd1022, 10'd5, 11'd3, 40, dk, bc, bf, bl);
    checks++;
    if (dk !== 10) begin errors++; $display("FAIL wrap_done_cycle: got %0d expected 10", dk); end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_log[(r0 + i) % 64] !== exp_a[i]) begin
        errors++; $display("FAIL wrap_rdaddr%0d: got %0d expected %0d", i, rd_log[(r0 + i) % 64], exp_a[i]);
      end
      checks++;
      if (mem[5+i] !== exp_d[i]) begin
        errors++; $display("FAIL wrap_data%0d: got %h expected %h", i, mem[5+i], exp_d[i]);
      end
    end
  endtask

  task automatic test_stall;
    int dk, bc, bf, bl, e0, w0;
    poke(10'd0, 32'hA0A0_0000);
    for (int i = 0; i < 4; i++) poke(10'(16 + i), 32'h0);
    e0 = stab_err; w0 = wr_cnt;
    stall_en = 1'b1;
    run_copy(10'd0, 10'd16, 11'd4, 600, dk, bc, bf, bl);
    stall_en = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (dk < 13) begin errors++; $display("FAIL stall_done: got %0d expected >=13 (negative means timeout)", dk); end
    checks++;
    if (stab_err - e0 !== 0) begin errors++; $display("FAIL stall_stable: got %0d changes expected 0", stab_err - e0); end
    checks++;
    if (wr_cnt - w0 !== 4) begin errors++; $display("FAIL stall_writes: got %0d expected 4", wr_cnt - w0); end
    checks++;
    if (both_cnt !== 0) begin errors++; $display("FAIL rd_wr_both: got %0d expected 0", both_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16+i] !== 32'hA0A0_0000 + i) begin
        errors++; $display("FAIL stall_data%0d: got %h expected %h", i, mem[16+i], 32'hA0A0_0000 + i);
      end
    end
  endtask

  task automatic test_reset_mid_copy;
    int dk, bc, bf, bl;
    bit saw_done;
    @(negedge clk);
    i_src_addr = 10'd0; i_dst_addr = 10'd32; i_length = 11'd4; i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (o_master_write !== 1'b1 || o_master_address !== 10'd33) begin
      errors++; $display("FAIL midrst_wr_req: write=%b addr=%0d expected 1 33", o_master_write, o_master_address);
    end
    i_reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_busy, o_done, o_master_read, o_master_write, o_master_byteenable} !== 8'h0 ||
        o_master_address !== 10'd0 || o_master_writedata !== 32'h0) begin
      errors++; $display("FAIL midrst_outputs: ctrl=%b addr=%0d wd=%h expected all 0",
                         {o_busy, o_done, o_master_read, o_master_write, o_master_byteenable}, o_master_address, o_master_writedata);
    end
    @(negedge clk);
    i_reset = 1'b0;
    saw_done = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (o_done || o_busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got activity=1 expected 0"); end
    run_copy(10'd1, 10'd40, 11'd2, 40, dk, bc, bf, bl);
    checks++;
    if (dk !== 7) begin errors++; $display("FAIL midrst_restart_done: got %0d expected 7", dk); end
    @(negedge clk);
    checks++;
    if (mem[40] !== 32'hA0A0_0001 || mem[41] !== 32'hA0A0_0002) begin
      errors++; $display("FAIL midrst_restart_data: got %h %h expected a0a00001 a0a00002", mem[40], mem[41]);
    end
  endtask

  task automatic test_start_ignored_and_checksum;
    int dk;
    bit extra;
    poke(10'd100, 32'h0000_0001);
    poke(10'd101, 32'h0000_0002);
    poke(10'd102, 32'hFFFF_FFFF);
    poke(10'd203, 32'h1234_5678);
    @(negedge clk);
    i_src_addr = 10'd100; i_dst_addr = 10'd200; i_length = 11'd3; i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    dk = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 4) begin
        i_src_addr = 10'd500; i_dst_addr = 10'd600; i_length = 11'd1; i_start = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      if (o_done) begin
        dk = k;
        break;
      end
    end
    checks++;
    if (dk !== 10) begin errors++; $display("FAIL busy_start_done: got %0d expected 10", dk); end
`ifdef COPIER_CHECKSUM_EN
    checks++;
    if (o_checksum !== 32'h0000_0002) begin
      errors++; $display("FAIL checksum_at_done: got %h expected 00000002", o_checksum);
    end
`endif
    // start coinciding with DONE must be dropped
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    extra = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (o_busy || o_done) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin errors++; $display("FAIL done_cycle_start: got activity=1 expected 0"); end
    checks++;
    if (mem[200] !== 32'h1 || mem[201] !== 32'h2 || mem[202] !== 32'hFFFF_FFFF || mem[203] !== 32'h1234_5678) begin
      errors++; $display("FAIL busy_start_data: got %h %h %h %h expected 00000001 00000002 ffffffff 12345678",
                         mem[200], mem[201], mem[202], mem[203]);
    end
`ifdef COPIER_CHECKSUM_EN
    checks++;
    if (o_checksum !== 32'h0000_0002) begin
      errors++; $display("FAIL checksum_hold: got %h expected 00000002", o_checksum);
    end
`endif
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0;
    i_src_addr = '0; i_dst_addr = '0; i_length = '0;
    test_reset();
    test_basic_copy();
    test_zero_length();
    test_wrap();
    test_stall();
    test_reset_mid_copy();
    test_start_ignored_and_checksum();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
